// File: rtl/alu_arb_pkg.sv
// Shared types and MIPS decode constants for the ALU arbiter.
// The optional overflow trap is enabled by defining ALU_ARB_OVF_TRAP_EN.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;

   // Only the signed forms trap; the unsigned variants report overflow but never trap.
   function automatic logic is_ovf_trap_op(input logic [31:0] instr);
      logic rtype_signed;
      rtype_signed = (instr[31:26] == OPC_RTYPE) &&
                     ((instr[5:0] == FUNCT_ADD) || (instr[5:0] == FUNCT_SUB));
      return rtype_signed || (instr[31:26] == OPC_ADDI);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   int unsigned idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld      = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_OVF_TRAP_EN to register an overflow trap for ADD/SUB/ADDI.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_instr,
   input  logic [NUM_REQ*32-1:0] req_rega,
   input  logic [NUM_REQ*32-1:0] req_regb,
   output logic [31:0]           alu_instruction,
   output logic [31:0]           alu_rega,
   output logic [31:0]           alu_regb,
   input  logic [31:0]           alu_result,
   input  logic [2:0]            alu_flags,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           resp_result,
   output logic [2:0]            resp_flags,
   output logic                  resp_trap
);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [31:0]        instr_q, instr_d, rega_q, rega_d, regb_q, regb_d;
   logic [31:0]        result_q, result_d;
   logic [2:0]         flags_q, flags_d;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_vld;
   logic               accept;
   int unsigned        sel;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The response side never feeds req_ready: acceptance depends on state only.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_vld)  state_d = ST_EXEC;
         ST_EXEC:                 state_d = ST_RESP;
         ST_RESP: if (resp_ready) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == ST_IDLE) ? grant : '0;
      resp_valid = (state_q == ST_RESP);
      accept     = (state_q == ST_IDLE) && grant_vld;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      instr_d  = instr_q;
      rega_d   = rega_q;
      regb_d   = regb_q;
      result_d = result_q;
      flags_d  = flags_q;
      sel      = 32'(grant_idx);
      if (accept) begin
         id_d     = grant_idx;
         instr_d  = req_instr[32*sel +: 32];
         rega_d   = req_rega[32*sel +: 32];
         regb_d   = req_regb[32*sel +: 32];
         rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state_q == ST_EXEC) begin
         result_d = alu_result;
         flags_d  = alu_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         id_q     <= '0;
         instr_q  <= '0;
         rega_q   <= '0;
         regb_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         instr_q  <= instr_d;
         rega_q   <= rega_d;
         regb_q   <= regb_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

`ifdef ALU_ARB_OVF_TRAP_EN
   logic trap_q, trap_d;

   always_comb begin
      trap_d = trap_q;
      if (state_q == ST_EXEC) trap_d = alu_flags[0] && is_ovf_trap_op(instr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trap_q <= 1'b0;
      else        trap_q <= trap_d;
   end

   assign resp_trap = trap_q;
`else
   assign resp_trap = 1'b0;
`endif

   assign alu_instruction = instr_q;
   assign alu_rega        = rega_q;
   assign alu_regb        = regb_q;
   assign resp_id         = id_q;
   assign resp_result     = result_q;
   assign resp_flags      = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in plus a round-robin request/response model.
module tb_alu_arbiter;

   localparam int N = 4;
   localparam logic [31:0] I_ADD   = 32'h00221820;
   localparam logic [31:0] I_ADDU  = 32'h00221821;
   localparam logic [31:0] I_SUB   = 32'h00221822;
   localparam logic [31:0] I_SUBU  = 32'h00221823;
   localparam logic [31:0] I_AND   = 32'h00221824;
   localparam logic [31:0] I_OR    = 32'h00221825;
   localparam logic [31:0] I_ADDI  = 32'h20220000;
   localparam logic [31:0] I_ADDIU = 32'h24220000;
   localparam logic [31:0] I_BEQ   = 32'h10220004;

   logic            clk, rst_n;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*32-1:0] req_instr, req_rega, req_regb;
   logic [31:0]     alu_instruction, alu_rega, alu_regb, alu_result;
   logic [2:0]      alu_flags, resp_flags;
   logic            resp_valid, resp_ready, resp_trap;
   logic [1:0]      resp_id;
   logic [31:0]     resp_result;

   logic [31:0] t_instr[N], t_a[N], t_b[N];
   bit          pend[N];
   int          mptr, checks, errors, cyc;

   alu_arbiter #(.NUM_REQ(N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_instr       (req_instr),
      .req_rega        (req_rega),
      .req_regb        (req_regb),
      .alu_instruction (alu_instruction),
      .alu_rega        (alu_rega),
      .alu_regb        (alu_regb),
      .alu_result      (alu_result),
      .alu_flags       (alu_flags),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_id         (resp_id),
      .resp_result     (resp_result),
      .resp_flags      (resp_flags),
      .resp_trap       (resp_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {zero, negative, overflow, result} for the small MIPS subset used here.
   function automatic logic [34:0] alu_ref(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r, imm;
      logic        ovf;
      imm = {{16{ins[15]}}, ins[15:0]};
      r   = 32'd0;
      ovf = 1'b0;
      case (ins[31:26])
         6'b000000: case (ins[5:0])
            6'h20, 6'h21: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            6'h22, 6'h23: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            6'h24:        r = a & b;
            6'h25:        r = a | b;
            default:      r = 32'd0;
         endcase
         6'b001000, 6'b001001: begin r = a + imm; ovf = (a[31] == imm[31]) && (r[31] != a[31]); end
         6'b000100: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
         default: r = 32'd0;
      endcase
      return {(r == 32'd0), r[31], ovf, r};
   endfunction

   function automatic logic trap_ref(input logic [31:0] ins, input logic ovf);
`ifdef ALU_ARB_OVF_TRAP_EN
      return ovf && (((ins[31:26] == 6'h00) && ((ins[5:0] == 6'h20) || (ins[5:0] == 6'h22)))
                     || (ins[31:26] == 6'h08));
`else
      return ovf && ins[31] && 1'b0;
`endif
   endfunction

   always_comb {alu_flags, alu_result} = alu_ref(alu_instruction, alu_rega, alu_regb);

   always_comb begin
      req_valid = '0;
      req_instr = '0;
      req_rega  = '0;
      req_regb  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = pend[i];
         req_instr[32*i +: 32] = t_instr[i];
         req_rega[32*i +: 32]  = t_a[i];
         req_regb[32*i +: 32]  = t_b[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic post(input int id, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      t_instr[id] = ins;
      t_a[id]     = a;
      t_b[id]     = b;
      pend[id]    = 1'b1;
   endtask

   // Model: grant is the first pending requester from mptr upward; then EXEC, RESP, IDLE.
   task automatic step_accept(input int hold, output int acc);
      int          g, waited;
      logic [34:0] e;
      logic        et;
      g   = -1;
      acc = 0;
      for (int k = 0; k < N; k++) if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      if (g < 0) return;
      e  = alu_ref(t_instr[g], t_a[g], t_b[g]);
      et = trap_ref(t_instr[g], e[32]);
      resp_ready = (hold == 0);
      #1;
      waited = 0;
      while (req_ready == '0 && waited < 20) begin
         @(posedge clk); @(negedge clk); #1;
         waited++;
      end
      check("grant", 32'(req_ready), 32'(1 << g));
      if (req_ready == '0) return;
      @(posedge clk); #1;
      acc     = cyc;
      pend[g] = 1'b0;
      mptr    = (g + 1) % N;
      @(negedge clk);
      check("exec_valid", 32'(resp_valid), 32'd0);
      check("exec_ready", 32'(req_ready), 32'd0);
      check("alu_instr", alu_instruction, t_instr[g]);
      check("alu_rega", alu_rega, t_a[g]);
      check("alu_regb", alu_regb, t_b[g]);
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_id", 32'(resp_id), 32'(g));
      check("resp_result", resp_result, e[31:0]);
      check("resp_flags", 32'(resp_flags), 32'(e[34:32]));
      check("resp_trap", 32'(resp_trap), 32'(et));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_result", resp_result, e[31:0]);
         check("hold_flags", 32'(resp_flags), 32'(e[34:32]));
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("back_idle", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev;
      logic [31:0] ops[9];
      checks = 0; errors = 0; cyc = 0; mptr = 0;
      for (int i = 0; i < N; i++) begin
         t_instr[i] = '0; t_a[i] = '0; t_b[i] = '0; pend[i] = 1'b0;
      end
      ops = '{I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_ADDI, I_ADDIU, I_BEQ};
      rst_n = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_alu_instr", alu_instruction, 32'd0);
      check("reset_result", resp_result, 32'd0);
      check("reset_trap", 32'(resp_trap), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Signed overflow on ADD from req0, then ADDU from req2.
      post(0, I_ADD, 32'h7FFFFFFF, 32'd1);
      step_accept(0, acc);
      post(2, I_ADDU, 32'h7FFFFFFF, 32'd1);
      step_accept(0, acc);

      // Pointer now 3: lone req1 is reached by wrapping.
      post(1, I_OR, 32'h0000F0F0, 32'h00000F0F);
      step_accept(0, acc);

      // Reset during EXEC discards the in-flight AND.
      post(1, I_AND, 32'h0000000C, 32'h0000000A);
      #1;
      for (int w = 0; w < 20 && req_ready == '0; w++) begin
         @(posedge clk); @(negedge clk); #1;
      end
      check("rst_grant", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      pend[1] = 1'b0;
      @(negedge clk);
      check("rst_exec_instr", alu_instruction, I_AND);
      rst_n = 1'b0;
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_alu_instr", alu_instruction, 32'd0);
      check("rst_alu_rega", alu_rega, 32'd0);
      check("rst_alu_regb", alu_regb, 32'd0);
      check("rst_result", resp_result, 32'd0);
      check("rst_flags", 32'(resp_flags), 32'd0);
      check("rst_id", 32'(resp_id), 32'd0);
      check("rst_trap", 32'(resp_trap), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mptr  = 0;
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         check("rst_no_resp", 32'(resp_valid), 32'd0);
      end

      // All four requesters contend: order 0..3, one accept every 3 cycles.
      for (int i = 0; i < N; i++) post(i, I_SUB, 32'd10, 32'd10);
      prev = 0;
      for (int i = 0; i < N; i++) begin
         step_accept(0, acc);
         if (i > 0) check("issue_interval", 32'(acc - prev), 32'd3);
         prev = acc;
      end

      // Consumer stalls for 5 cycles while another requester waits.
      post(0, I_BEQ, 32'd10, 32'd10);
      post(2, I_ADDU, 32'd5, 32'd6);
      step_accept(5, acc);
      step_accept(0, acc);

      // Randomized traffic with random back-pressure.
      for (int it = 0; it < 40; it++) begin
         bit any;
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               logic [31:0] a, b, ins;
               ins = ops[$urandom_range(0, 8)];
               if (ins[31:26] == 6'b001000 || ins[31:26] == 6'b001001)
                  ins[15:0] = 16'($urandom);
               a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
               b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
               post(i, ins, a, b);
            end
         end
         for (int i = 0; i < N; i++) if (pend[i]) any = 1'b1;
         if (!any) post($urandom_range(0, N - 1), I_ADD, $urandom, $urandom);
         step_accept($urandom_range(0, 2), acc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
